// File: rtl/vlsu_cam_alloc_ctrl_pkg.sv
// Shared types and sizing for the VLSU CAM and its allocation controller.
// Optional feature macro (used by the top): VLSU_CAM_ALLOC_PERF_EN.
package vlsu_cam_pkg;

    localparam int WIDTH   = 50;
    localparam int DEPTH   = 32;
    localparam int READ    = 3;
    localparam int ADDRESS = $clog2(DEPTH);

    typedef logic [WIDTH-1:0]   width_t;
    typedef logic [ADDRESS-1:0] addr_t;
    typedef logic [ADDRESS:0]   depth_t;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/vlsu_cam_alloc_ctrl_if.sv
// Producer-side allocation handshake into the CAM allocation controller.
interface vlsu_cam_alloc_if;
    import vlsu_cam_pkg::*;

    logic   alloc_valid_i;
    width_t alloc_data_i;
    logic   alloc_ready_o;
    addr_t  alloc_addr_o;

    modport master (
        output alloc_valid_i,
        output alloc_data_i,
        input  alloc_ready_o,
        input  alloc_addr_o
    );

    modport slave (
        input  alloc_valid_i,
        input  alloc_data_i,
        output alloc_ready_o,
        output alloc_addr_o
    );

endinterface

// File: rtl/vlsu_cam_alloc_ctrl_valid_mask.sv
// Per-entry live bits for the CAM, replicated onto every lookup lane.
module vlsu_cam_valid_mask
    import vlsu_cam_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  addr_t                 set_idx,
    input  logic                  clr_en,
    input  addr_t                 clr_idx,
    input  logic                  clr_all,
    output logic [READ*DEPTH-1:0] enable_o
);

    logic [DEPTH-1:0] mask_d, mask_q;

    always_comb begin
        // NOTE: default assignment first so every path drives mask_d and no latch is inferred.
        mask_d = mask_q;
        if (clr_en)  mask_d[clr_idx] = 1'b0;
        if (set_en)  mask_d[set_idx] = 1'b1;
        if (clr_all) mask_d = '0;
    end

    // NOTE: unlike CAM payload storage, live bits are control state and must come out of reset cleared.
    always_ff @(posedge clk) begin
        if (rst) mask_q <= '0;
        else     mask_q <= mask_d;
    end

    assign enable_o = {READ{mask_q}};

endmodule

// File: rtl/vlsu_cam_alloc_ctrl.sv
// CAM allocation controller: zero-init sweep, circular-buffer alloc/retire, lane enables.
// Optional macro VLSU_CAM_ALLOC_PERF_EN adds saturating stall/alloc counters.
module vlsu_cam_alloc_ctrl
    import vlsu_cam_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    vlsu_cam_alloc_if.slave       alloc,
    input  logic                  retire_i,
    input  logic                  flush_i,
    output logic                  cam_write_o,
    output addr_t                 cam_write_addr_o,
    output width_t                cam_write_data_o,
    output addr_t                 cam_head_o,
    output logic [READ*DEPTH-1:0] cam_enable_o,
    output depth_t                count_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  init_done_o
`ifdef VLSU_CAM_ALLOC_PERF_EN
    ,
    output logic [31:0]           stall_cnt_o,
    output logic [31:0]           alloc_cnt_o
`endif
);

    state_e state_d, state_q;
    addr_t  sweep_d, sweep_q;
    addr_t  head_d, head_q;
    addr_t  tail_d, tail_q;
    depth_t count_d, count_q;
    logic   wr_d, wr_q;
    addr_t  wr_addr_d, wr_addr_q;
    width_t wr_data_d, wr_data_q;
    logic   run, fire, retire_ok;

    assign run       = (state_q == S_RUN);
    assign full_o    = (count_q == depth_t'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign alloc.alloc_ready_o = run && !full_o && !flush_i;
    assign alloc.alloc_addr_o  = head_q;
    assign fire      = alloc.alloc_valid_i && alloc.alloc_ready_o;
    assign retire_ok = run && retire_i && !empty_o && !flush_i;

    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        wr_d      = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (flush_i) begin
            state_d = S_INIT;
            sweep_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            case (state_q)
                S_INIT: begin
                    wr_d      = 1'b1;
                    wr_addr_d = sweep_q;
                    wr_data_d = '0;
                    sweep_d   = sweep_q + 1'b1;
                    if (sweep_q == addr_t'(DEPTH - 1)) state_d = S_RUN;
                end
                S_RUN: begin
                    if (fire) begin
                        wr_d      = 1'b1;
                        wr_addr_d = head_q;
                        wr_data_d = alloc.alloc_data_i;
                        head_d    = head_q + 1'b1;
                    end
                    if (retire_ok) tail_d = tail_q + 1'b1;
                    // Simultaneous fire and retire leaves the occupancy unchanged.
                    case ({fire, retire_ok})
                        2'b10:   count_d = count_q + 1'b1;
                        2'b01:   count_d = count_q - 1'b1;
                        default: count_d = count_q;
                    endcase
                end
                default: state_d = S_INIT;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_INIT;
            sweep_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            wr_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            sweep_q   <= sweep_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            wr_q      <= wr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    vlsu_cam_valid_mask u_valid_mask (
        .clk      (clk),
        .rst      (rst),
        .set_en   (fire),
        .set_idx  (head_q),
        .clr_en   (retire_ok),
        .clr_idx  (tail_q),
        .clr_all  (flush_i),
        .enable_o (cam_enable_o)
    );

    assign cam_write_o      = wr_q;
    assign cam_write_addr_o = wr_addr_q;
    assign cam_write_data_o = wr_data_q;
    assign cam_head_o       = tail_q;
    assign count_o          = count_q;
    assign init_done_o      = run;

`ifdef VLSU_CAM_ALLOC_PERF_EN
    logic [31:0] stall_cnt_d, stall_cnt_q;
    logic [31:0] alloc_cnt_d, alloc_cnt_q;

    // Counters survive flush on purpose; only rst clears them.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        alloc_cnt_d = alloc_cnt_q;
        if (run && alloc.alloc_valid_i && !alloc.alloc_ready_o && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (fire && (alloc_cnt_q != '1))
            alloc_cnt_d = alloc_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            alloc_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            alloc_cnt_q <= alloc_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign alloc_cnt_o = alloc_cnt_q;
`endif

endmodule
